// File: rtl/fe_ci_pkg.sv
// Shared types and constants for the float custom-instruction initiator.
package fe_ci_pkg;
    localparam int FLT_DATA_WIDTH = 32;
    localparam int N_WIDTH        = 2;

    typedef logic [N_WIDTH-1:0] ci_op_t;
    localparam ci_op_t CLEAR = 2'd0;
    localparam ci_op_t GO    = 2'd1;
    localparam ci_op_t READ  = 2'd2;

    localparam logic [FLT_DATA_WIDTH-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [3:0] {
        IDLE, FILL_B, GO_ISSUE, GO_WAIT, RD_ISSUE, RD_WAIT, CL_ISSUE, CL_WAIT, OUT
    } state_t;

    function automatic logic is_issue(input state_t s);
        return (s == GO_ISSUE) || (s == RD_ISSUE) || (s == CL_ISSUE);
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == GO_WAIT) || (s == RD_WAIT) || (s == CL_WAIT);
    endfunction
endpackage

// File: rtl/fe_ci_watchdog.sv
// Wait-cycle watchdog: cleared by load, advances while count is high, flags the final cycle.
module fe_ci_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] cnt;

    assign expire = count && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (count && !expire)
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/fe_ci_initiator.sv
// Feeds float operand pairs to a custom-instruction evaluator (GO), then READs and CLEARs it.
// Define FE_CI_TIMEOUT_EN to bound every wait for ci_done by TIMEOUT_CYCLES.
module fe_ci_initiator
    import fe_ci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLT_DATA_WIDTH-1:0] in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [FLT_DATA_WIDTH-1:0] out_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ci_clk_en,
    output logic                      ci_start,
    output logic [N_WIDTH-1:0]        ci_n,
    output logic [FLT_DATA_WIDTH-1:0] ci_x_one,
    output logic [FLT_DATA_WIDTH-1:0] ci_x_two,
    input  logic [FLT_DATA_WIDTH-1:0] ci_result,
    input  logic                      ci_done,
    output logic                      busy,
    output logic                      timeout_err
);
    state_t state;
    logic   last_seen;
    logic   expire;

    assign in_ready  = !rst && ((state == IDLE) || (state == FILL_B));
    assign busy      = (state != IDLE);
    assign ci_clk_en = !rst;

`ifdef FE_CI_TIMEOUT_EN
    fe_ci_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (is_issue(state)),
        .count  (is_wait(state)),
        .expire (expire)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign expire     = 1'b0;
`endif

    // ci_n/ci_x_* only change on operand accept or when entering an ISSUE state,
    // so they stay put for the whole start..done window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_seen   <= 1'b0;
            ci_start    <= 1'b0;
            ci_n        <= CLEAR;
            ci_x_one    <= '0;
            ci_x_two    <= '0;
            out_result  <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ci_start <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    ci_x_one <= in_data;
                    if (in_last) begin
                        ci_x_two  <= '0;
                        last_seen <= 1'b1;
                        ci_n      <= GO;
                        ci_start  <= 1'b1;
                        state     <= GO_ISSUE;
                    end else begin
                        state <= FILL_B;
                    end
                end
                FILL_B: if (in_valid) begin
                    ci_x_two  <= in_data;
                    last_seen <= in_last;
                    ci_n      <= GO;
                    ci_start  <= 1'b1;
                    state     <= GO_ISSUE;
                end
                GO_ISSUE: state <= GO_WAIT;
                RD_ISSUE: state <= RD_WAIT;
                CL_ISSUE: state <= CL_WAIT;
                GO_WAIT: if (ci_done) begin
                    if (last_seen) begin
                        ci_n     <= READ;
                        ci_start <= 1'b1;
                        state    <= RD_ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: if (ci_done) begin
                    out_result <= ci_result;
                    ci_n       <= CLEAR;
                    ci_start   <= 1'b1;
                    state      <= CL_ISSUE;
                end
                CL_WAIT: if (ci_done) begin
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    last_seen <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A late ci_done still wins over the watchdog in the same cycle.
            if (is_wait(state) && !ci_done && expire) begin
                timeout_err <= 1'b1;
                out_result  <= QNAN;
                out_valid   <= 1'b1;
                state       <= OUT;
            end
        end
    end
endmodule

// File: tb/tb_fe_ci_initiator.sv
// Randomized bench for fe_ci_initiator with an evaluator model and a transaction scoreboard.
module tb_fe_ci_initiator;
    import fe_ci_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [31:0] out_result;
    logic        out_valid, out_ready = 1'b0;
    logic        ci_clk_en, ci_start;
    logic [1:0]  ci_n;
    logic [31:0] ci_x_one, ci_x_two, ci_result = '0;
    logic        ci_done = 1'b0, busy, timeout_err;

    fe_ci_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_result(out_result), .out_valid(out_valid),
        .out_ready(out_ready), .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
        .ci_x_one(ci_x_one), .ci_x_two(ci_x_two), .ci_result(ci_result),
        .ci_done(ci_done), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic l; } op_t;
    typedef struct { logic [1:0] n; logic [31:0] x1; logic [31:0] x2; bit chkx; } tx_t;

    op_t         feed[$];
    tx_t         exp_tx[$];
    logic [31:0] rd_val[$], exp_res[$];
    logic [1:0]  log_n[$];
    logic [31:0] log_x1[$], log_x2[$];

    int total = 0, bad = 0, n_out = 0, nexp = 0;
    logic [31:0] last_out = '0;
    bit pend = 0, hang = 0, hold_rdy = 0, gap_en = 0;
    int cnt = 0, wcnt = 0, to_wait = -1, dly_min = 1, dly_max = 1;
    logic [1:0]  sv_n = '0;
    logic [31:0] sv_x1 = '0, sv_x2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected transactions: operands in pairs (odd tail paired with 0), then READ, CLEAR.
    task automatic push_vec(input logic [31:0] ops[$], input logic [31:0] res);
        for (int i = 0; i < ops.size(); i++) feed.push_back('{ops[i], (i == ops.size() - 1)});
        for (int i = 0; i < ops.size(); i += 2)
            exp_tx.push_back('{GO, ops[i], (i + 1 < ops.size()) ? ops[i+1] : 32'h0, 1'b1});
        exp_tx.push_back('{READ, 32'h0, 32'h0, 1'b0});
        exp_tx.push_back('{CLEAR, 32'h0, 32'h0, 1'b0});
        rd_val.push_back(res);
        exp_res.push_back(res);
        nexp++;
    endtask

    task automatic wait_outs(input string name);
        int k = 0;
        while (n_out < nexp && k < 3000) begin @(posedge clk); k++; end
        chk(name, n_out, nexp);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_n.delete(); log_x1.delete(); log_x2.delete();
    endtask

    // Evaluator model, scoreboard, operand feeder and result sink; all act mid-cycle.
    always @(negedge clk) begin
        ci_done = 1'b0;
        if (rst) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end else begin
            chk("clk_en", ci_clk_en, 1);
            if (!hang) chk("tmo_flag", timeout_err, 0);
            if (pend || out_valid) begin
                chk("in_ready_blocked", in_ready, 0);
                chk("busy", busy, 1);
            end
            if (pend) begin
                if (out_valid) begin
                    pend    = 0;
                    to_wait = wcnt;
                end else begin
                    wcnt++;
                    chk("no_restart", ci_start, 0);
                    chk("n_stable", ci_n, sv_n);
                    chk("x1_stable", ci_x_one, sv_x1);
                    chk("x2_stable", ci_x_two, sv_x2);
                    if (!hang) begin
                        if (cnt <= 1) begin
                            ci_done   = 1'b1;
                            ci_result = (sv_n == READ && rd_val.size() > 0) ? rd_val.pop_front() : $urandom;
                            pend      = 0;
                        end else cnt--;
                    end
                end
            end else begin
                if (gap_en && $urandom_range(7) == 0) begin
                    ci_done   = 1'b1;
                    ci_result = $urandom;
                end
                if (ci_start) begin
                    tx_t t;
                    log_n.push_back(ci_n); log_x1.push_back(ci_x_one); log_x2.push_back(ci_x_two);
                    if (exp_tx.size() == 0) chk("unexpected_start", ci_start, 0);
                    else begin
                        t = exp_tx.pop_front();
                        chk("op", ci_n, t.n);
                        if (t.chkx) begin
                            chk("go_x1", ci_x_one, t.x1);
                            chk("go_x2", ci_x_two, t.x2);
                        end
                    end
                    sv_n = ci_n; sv_x1 = ci_x_one; sv_x2 = ci_x_two;
                    pend = 1; wcnt = 0;
                    cnt  = $urandom_range(dly_max, dly_min);
                end
            end
            if (out_valid) begin
                if (exp_res.size() == 0) chk("unexpected_out", out_valid, 0);
                else chk("out_result", out_result, exp_res[0]);
            end
            out_ready = hold_rdy ? 1'b0 : ($urandom_range(2) != 0);
            if (out_valid && out_ready) begin
                if (exp_res.size() > 0) void'(exp_res.pop_front());
                last_out = out_result;
                n_out++;
            end
            if (feed.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                in_valid = 1'b1;
                in_data  = feed[0].d;
                in_last  = feed[0].l;
                if (in_ready) void'(feed.pop_front());
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = $urandom_range(1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] v[$];
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ci_start", ci_start, 0);
        chk("rst_ci_n", ci_n, CLEAR);
        chk("rst_x1", ci_x_one, 0);
        chk("rst_x2", ci_x_two, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_tmo", timeout_err, 0);
        chk("rst_clk_en", ci_clk_en, 0);
        rst = 1'b0;

        // 1.0 + 2.0 -> one GO, READ, CLEAR
        clear_log();
        v.delete(); v.push_back(32'h3F800000); v.push_back(32'h40000000);
        push_vec(v, 32'h40400000);
        wait_outs("t1_outs");
        chk("t1_result", last_out, 32'h40400000);
        chk("t1_nstarts", log_n.size(), 3);
        chk("t1_go_x1", log_x1[0], 32'h3F800000);
        chk("t1_go_x2", log_x2[0], 32'h40000000);
        chk("t1_rd_op", log_n[1], READ);
        chk("t1_cl_op", log_n[2], CLEAR);

        // odd operand count: tail paired with zero
        clear_log();
        v.delete(); v.push_back(32'h3F800000); v.push_back(32'h40000000); v.push_back(32'h40400000);
        push_vec(v, 32'h40C00000);
        wait_outs("t2_outs");
        chk("t2_nstarts", log_n.size(), 4);
        chk("t2_tail_x1", log_x1[1], 32'h40400000);
        chk("t2_tail_x2", log_x2[1], 32'h00000000);
        chk("t2_result", last_out, 32'h40C00000);

        // downstream stall: result held 10 cycles
        hold_rdy = 1;
        v.delete(); v.push_back(32'h12345678);
        push_vec(v, 32'hCAFEF00D);
        k = 0;
        while (!out_valid && k < 200) begin @(posedge clk); k++; end
        repeat (10) @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, 32'hCAFEF00D);
        chk("hold_in_ready", in_ready, 0);
        hold_rdy = 0;
        wait_outs("t3_outs");

        // slow evaluator, in_data toggling while waiting
        clear_log();
        dly_min = 5; dly_max = 5;
        v.delete(); v.push_back(32'hBF800000); v.push_back(32'h41200000);
        push_vec(v, 32'h0BADBEEF);
        wait_outs("t4_outs");
        chk("t4_nstarts", log_n.size(), 3);

        // randomized vectors, gaps, spurious done pulses, random latencies
        gap_en = 1; dly_min = 1; dly_max = 4;
        for (int i = 0; i < 40; i++) begin
            v.delete();
            for (int j = 0; j < $urandom_range(5, 1); j++) v.push_back($urandom);
            push_vec(v, $urandom);
        end
        wait_outs("rand_outs");
        chk("rand_drained", exp_tx.size(), 0);
        chk("rand_idle", busy, 0);
        gap_en = 0;

        // reset in GO_WAIT abandons the vector
        dly_min = 5; dly_max = 5;
        v.delete(); v.push_back(32'h3F800000); v.push_back(32'h40000000); v.push_back(32'h40400000);
        push_vec(v, 32'h11111111);
        k = 0;
        while (!(pend && sv_n == GO) && k < 200) begin @(posedge clk); k++; end
        chk("reach_go_wait", pend, 1);
        #1 rst = 1'b1;
        feed.delete(); exp_tx.delete(); rd_val.delete(); exp_res.delete();
        pend = 0; nexp = n_out;
        @(posedge clk);
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ci_start", ci_start, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        rst = 1'b0;
        clear_log();
        dly_min = 1; dly_max = 3;
        v.delete(); v.push_back(32'h40800000);
        push_vec(v, 32'h22222222);
        wait_outs("post_rst_outs");
        chk("post_rst_result", last_out, 32'h22222222);
        chk("post_rst_first_op", log_n[0], GO);

`ifdef FE_CI_TIMEOUT_EN
        // evaluator never answers: watchdog fires after TMO wait cycles
        hang = 1; hold_rdy = 1;
        feed.push_back('{32'h3F800000, 1'b1});
        exp_tx.push_back('{GO, 32'h3F800000, 32'h0, 1'b1});
        exp_res.push_back(32'h7FC00000);
        nexp++;
        k = 0;
        while (!out_valid && k < 200) begin @(posedge clk); k++; end
        @(negedge clk);
        #1;
        chk("tmo_wait_cycles", to_wait, TMO);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_result", out_result, 32'h7FC00000);
        chk("tmo_valid", out_valid, 1);
        hold_rdy = 0;
        wait_outs("tmo_outs");
        chk("tmo_sticky", timeout_err, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("tmo_cleared", timeout_err, 0);
        rst = 1'b0;
        hang = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
